// File: rtl/cla_multiword_sequencer.sv
// ---------------------------------------------------------------------------
// cla_multiword_sequencer
//
// Adds or subtracts two WORDS*N-bit operands over WORDS cycles using one
// N-bit carry-look-ahead adder slice. The least significant word is processed
// first, and the carry is registered between words. This trades latency for
// area: one op takes WORDS+1 cycles from an accepted start to done.
//
// Ports
//   clk     in   1  system clock, rising edge
//   rst_n   in   1  asynchronous active-low reset
//   start   in   1  request, sampled only when busy=0
//   op_sub  in   1  0: A+B+C_in, 1: A-B
//   A, B    in   W  operands, captured with an accepted start
//   C_in    in   1  carry in for add (ignored when op_sub=1)
//   busy    out  1  computation in progress
//   done    out  1  one-cycle pulse; S/C_out/ovf valid
//   S       out  W  result, held from done until the next accepted start
//   C_out   out  1  carry out of MSB (subtract: 1 = no borrow)
//   ovf     out  1  two's-complement overflow of the W-bit result
//
// Also contains carry_look_ahead_adder, the N-bit slice used by the sequencer.
// ---------------------------------------------------------------------------

module carry_look_ahead_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] s,
    output logic         c_out
);
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    logic         acc;
    logic         term;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_bit
            assign g[gi] = a[gi] & b[gi];
            assign p[gi] = a[gi] ^ b[gi];
            assign s[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    // Each carry is expanded into its flat sum of products:
    //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in
    // so no carry depends on a lower carry. That is the look-ahead structure,
    // as opposed to a ripple chain.
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        term = 1'b0;
        c[0] = c_in;
        for (int i = 0; i < N; i++) begin
            acc = c_in;
            for (int j = 0; j <= i; j++) begin
                acc = acc & p[j];
            end
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            c[i+1] = acc;
        end
    end

    assign c_out = c[N];
endmodule

module cla_multiword_sequencer #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               op_sub,
    input  logic [N*WORDS-1:0] A,
    input  logic [N*WORDS-1:0] B,
    input  logic               C_in,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] S,
    output logic               C_out,
    output logic               ovf
);
    localparam int W  = N * WORDS;
    localparam int CW = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;        // B already inverted for subtract
    logic [W-1:0]  s_q, s_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  sum_w;
    logic          cout_w;

    // Operands shift right every RUN cycle, so the current word is always in
    // the low N bits and the adder needs no word-select mux.
    carry_look_ahead_adder #(.N(N)) u_cla (
        .a     (a_q[N-1:0]),
        .b     (b_q[N-1:0]),
        .c_in  (carry_q),
        .s     (sum_w),
        .c_out (cout_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B ^ {W{op_sub}};
                    carry_d = op_sub ? 1'b1 : C_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = {{N{1'b0}}, a_q[W-1:N]};
                b_d     = {{N{1'b0}}, b_q[W-1:N]};
                // Shifting in from the MS end leaves word 0 at the bottom
                // after WORDS steps.
                s_d     = {sum_w, s_q[W-1:N]};
                carry_d = cout_w;
                if (cnt_q == CW'(WORDS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    cout_d  = cout_w;
                    // In the last word, the low N bits of a_q and b_q hold
                    // the operand MSBs.
                    ovf_d   = (a_q[N-1] == b_q[N-1]) && (sum_w[N-1] != a_q[N-1]);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign S     = s_q;
    assign C_out = cout_q;
    assign ovf   = ovf_q;
endmodule
